// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: access size codes,
// FSM state encoding, default data width and the alignment rule.
package mem_defs;

    localparam int BITS_DEFAULT = 32;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    // An illegal size code is reported the same way as a misaligned address.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return lo[0];
            SIZE_W:  return (lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte/half lane handling: extracts and extends load data from a memory word,
// and merges right-justified store data into the addressed lane of a word.
module mem_lane_align
    import mem_defs::*;
#(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      size,
    input  logic            uns,
    input  logic [BITS-1:0] rd_word,
    input  logic [BITS-1:0] mg_word,
    input  logic [BITS-1:0] wdata,
    output logic [BITS-1:0] load_data,
    output logic [BITS-1:0] merge_word
);

    logic [4:0]      sh;
    logic [BITS-1:0] rd_sh;
    logic [BITS-1:0] lane_mask;
    logic [BITS-1:0] pos_mask;

    // Aligned halves have addr_lo[0]=0, so one byte-granular shift serves both sizes.
    assign sh    = {addr_lo, 3'b000};
    assign rd_sh = rd_word >> sh;

    always_comb begin
        load_data = rd_sh;
        case (size)
            SIZE_B:  load_data = {{(BITS-8){~uns & rd_sh[7]}}, rd_sh[7:0]};
            SIZE_H:  load_data = {{(BITS-16){~uns & rd_sh[15]}}, rd_sh[15:0]};
            default: load_data = rd_sh;
        endcase
    end

    always_comb begin
        lane_mask = '1;
        case (size)
            SIZE_B:  lane_mask = BITS'(8'hFF);
            SIZE_H:  lane_mask = BITS'(16'hFFFF);
            default: lane_mask = '1;
        endcase
    end

    assign pos_mask   = lane_mask << sh;
    assign merge_word = (mg_word & ~pos_mask) | ((wdata << sh) & pos_mask);

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store unit driving a single-port data memory; sub-word
// stores are done as read-modify-write, misaligned accesses report an error.
module mem_access_unit
    import mem_defs::*;
#(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [BITS-1:0] req_addr,
    input  logic [BITS-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [BITS-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic [BITS-1:0] memAdr,
    output logic [BITS-1:0] writeData,
    output logic            memRead,
    output logic            memWrite,
    input  logic [BITS-1:0] readData,
    output logic [1:0]      dbg_state
);

    // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
    // a response transfers where rsp_valid && rsp_ready, and is held until then.
    state_t          state;
    logic [BITS-1:0] addr_q;
    logic [1:0]      size_q;
    logic            we_q;
    logic            uns_q;
    logic [BITS-1:0] wdata_q;
    logic [BITS-1:0] word_q;
    logic [BITS-1:0] rsp_rdata_q;
    logic            rsp_err_q;
    logic [BITS-1:0] load_data;
    logic [BITS-1:0] merge_word;

    mem_lane_align #(.BITS(BITS)) u_lane (
        .addr_lo    (addr_q[1:0]),
        .size       (size_q),
        .uns        (uns_q),
        .rd_word    (readData),
        .mg_word    (word_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_word (merge_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            word_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        size_q      <= req_size;
                        we_q        <= req_we;
                        uns_q       <= req_unsigned;
                        wdata_q     <= req_wdata;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        if (misaligned(req_size, req_addr[1:0])) begin
                            rsp_err_q <= 1'b1;
                            state     <= RESP;
                        end else if (!req_we || req_size != SIZE_W) begin
                            state <= READ;
                        end else begin
                            state <= WRITE;
                        end
                    end
                end
                READ: begin
                    word_q <= readData;
                    if (we_q) begin
                        state <= WRITE;
                    end else begin
                        rsp_rdata_q <= load_data;
                        state       <= RESP;
                    end
                end
                WRITE: state <= RESP;
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode from state alone, so an async reset removes them immediately.
    assign req_ready = (state == IDLE);
    assign memRead   = (state == READ);
    assign memWrite  = (state == WRITE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign memAdr    = {addr_q[BITS-1:2], 2'b00};
    assign writeData = memWrite ? merge_word : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of single accesses plus
// response back-pressure and reset-during-write sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_adr;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] read_data;
  logic [1:0]  dbg_state;

  mem_access_unit #(.BITS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .memAdr       (mem_adr),
    .writeData    (write_data),
    .memRead      (mem_read),
    .memWrite     (mem_write),
    .readData     (read_data),
    .dbg_state    (dbg_state)
  );

  // clock / memory model
  always #5 clk = ~clk;

  logic [31:0] mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_val = 32'h0;

  assign read_data = mem[mem_adr[7:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_write) mem[mem_adr[7:2]] <= write_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // driver tasks
  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  int s_rd, s_wr, s_both;
  logic [31:0] s_adr;

  task automatic sample_strobes();
    if (mem_read) s_rd++;
    if (mem_write) s_wr++;
    if (mem_read && mem_write) s_both++;
    if (mem_read || mem_write) s_adr = mem_adr;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_init;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_mem;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs[14];

  task automatic run_vec(input vec_t v, input int k);
    int lat;
    string nm;
    nm = $sformatf("vec%0d", k);
    preload(v.addr[7:2], v.mem_init);
    chk({nm, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF; req_size = 2'b00;
    lat = 1; s_rd = 0; s_wr = 0; s_both = 0; s_adr = 32'h0;
    sample_strobes();
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      sample_strobes();
    end
    chk({nm, "_latency"}, lat, v.exp_lat);
    chk({nm, "_rdata"}, rsp_rdata, v.exp_rdata);
    chk({nm, "_err"}, {31'b0, rsp_err}, {31'b0, v.exp_err});
    chk({nm, "_reads"}, s_rd, v.exp_rd);
    chk({nm, "_writes"}, s_wr, v.exp_wr);
    chk({nm, "_overlap"}, s_both, 32'd0);
    if (v.exp_rd + v.exp_wr > 0) chk({nm, "_memadr"}, s_adr, {v.addr[31:2], 2'b00});
    chk({nm, "_mem"}, mem[v.addr[7:2]], v.exp_mem);
    chk({nm, "_busy"}, {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk({nm, "_rsp_done"}, {31'b0, rsp_valid}, 32'd0);
    chk({nm, "_ready_again"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    // we size uns addr wdata mem_init exp_rdata err lat exp_mem rd wr
    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h8899AABB, 32'h8899AABB, 1'b0, 2, 32'h8899AABB, 1, 0};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'h80FFFF01, 32'hFFFFFF80, 1'b0, 2, 32'h80FFFF01, 1, 0};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h80FFFF01, 32'h00000080, 1'b0, 2, 32'h80FFFF01, 1, 0};
    vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h21, 32'h5A,       32'h11223344, 32'h0,        1'b0, 3, 32'h11225A44, 1, 1};
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h02, 32'h0,        32'h7FFF1234, 32'h00007FFF, 1'b0, 2, 32'h7FFF1234, 1, 0};
    vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h06, 32'h0,        32'hA5A5A5A5, 32'h0,        1'b1, 1, 32'hA5A5A5A5, 0, 0};
    vecs[6]  = '{1'b1, 2'b11, 1'b0, 32'h08, 32'h12345678, 32'h0BADF00D, 32'h0,        1'b1, 1, 32'h0BADF00D, 0, 0};
    vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h30, 32'hDEADBEEF, 32'h0,        32'h0,        1'b0, 2, 32'hDEADBEEF, 0, 1};
    vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h1A, 32'h0,        32'h8001CAFE, 32'hFFFF8001, 1'b0, 2, 32'h8001CAFE, 1, 0};
    vecs[9]  = '{1'b0, 2'b01, 1'b1, 32'h1A, 32'h0,        32'h8001CAFE, 32'h00008001, 1'b0, 2, 32'h8001CAFE, 1, 0};
    vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h2E, 32'hABCD,     32'h12345678, 32'h0,        1'b0, 3, 32'hABCD5678, 1, 1};
    vecs[11] = '{1'b1, 2'b00, 1'b0, 32'h40, 32'hFFFFFF77, 32'hAABBCCDD, 32'h0,        1'b0, 3, 32'hAABBCC77, 1, 1};
    vecs[12] = '{1'b0, 2'b01, 1'b0, 32'h05, 32'h0,        32'h5555AAAA, 32'h0,        1'b1, 1, 32'h5555AAAA, 0, 0};
    vecs[13] = '{1'b1, 2'b01, 1'b0, 32'h37, 32'hFFFF,     32'h01020304, 32'h0,        1'b1, 1, 32'h01020304, 0, 0};

    // reset state
    #12;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_adr", mem_adr, 32'h0);
    chk("rst_write_data", write_data, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // back-pressure: response held stable while rsp_ready is low
    preload(6'd4, 32'hCAFEF00D);
    preload(6'd5, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("hold_valid_start", {31'b0, rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_valid", i), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("hold%0d_rdata", i), rsp_rdata, 32'hCAFEF00D);
      chk($sformatf("hold%0d_err", i), {31'b0, rsp_err}, 32'd0);
      chk($sformatf("hold%0d_req_ready", i), {31'b0, req_ready}, 32'd0);
      chk($sformatf("hold%0d_mem_write", i), {31'b0, mem_write}, 32'd0);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_valid", {31'b0, rsp_valid}, 32'd0);
    chk("hold_release_ready", {31'b0, req_ready}, 32'd1);
    chk("hold_ignored_store", mem[5], 32'h0);

    // reset during the write phase of a half store
    preload(6'd20, 32'h11112222);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h52; req_wdata = 32'h3333;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstw_read", {31'b0, mem_read}, 32'd1);
    @(posedge clk); #1;
    chk("rstw_write_before", {31'b0, mem_write}, 32'd1);
    chk("rstw_wdata_before", write_data, 32'h33332222);
    #2 rst = 1'b1;
    #1;
    chk("rstw_write_dropped", {31'b0, mem_write}, 32'd0);
    chk("rstw_wdata_cleared", write_data, 32'h0);
    chk("rstw_state_idle", {30'b0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    chk("rstw_mem_unchanged", mem[20], 32'h11112222);
    @(negedge clk); rst = 1'b0;
    #1 chk("rstw_ready_after", {31'b0, req_ready}, 32'd1);
    chk("rstw_memadr_cleared", mem_adr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rstw_no_rsp%0d", i), {31'b0, rsp_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
